// File: rtl/text_pkg.sv
// Shared constants for the text row path.
// Purpose: glyph ID codes used by game/score logic, the blank cell code,
// screen geometry and the sequencer FSM state type.
// Ports: none (package).
package text_pkg;

    // Glyph ID codes understood by the renderer.
    localparam logic [5:0] ID_DASH  = 6'd0;
    localparam logic [5:0] ID_A     = 6'd1;
    localparam logic [5:0] ID_B     = 6'd2;
    localparam logic [5:0] ID_C     = 6'd3;
    localparam logic [5:0] ID_D     = 6'd4;
    localparam logic [5:0] ID_E     = 6'd5;
    localparam logic [5:0] ID_G     = 6'd7;
    localparam logic [5:0] ID_H     = 6'd8;
    localparam logic [5:0] ID_K     = 6'd11;
    localparam logic [5:0] ID_M     = 6'd13;
    localparam logic [5:0] ID_O     = 6'd15;
    localparam logic [5:0] ID_R     = 6'd18;
    localparam logic [5:0] ID_U     = 6'd21;
    localparam logic [5:0] ID_V     = 6'd22;
    localparam logic [5:0] ID_Y     = 6'd25;
    localparam logic [5:0] ID_ONE   = 6'd29;
    localparam logic [5:0] ID_TWO   = 6'd30;
    localparam logic [5:0] ID_THREE = 6'd31;
    localparam logic [5:0] ID_FOUR  = 6'd32;
    localparam logic [5:0] ID_FIVE  = 6'd24;
    localparam logic [5:0] ID_SIX   = 6'd26;
    localparam logic [5:0] ID_SEVEN = 6'd27;
    localparam logic [5:0] ID_EIGHT = 6'd28;

    // A cell holding this code is never drawn.
    localparam logic [5:0] BLANK_ID = 6'd63;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // FILL: shadow buffer open for writes.
    // PENDING: shadow committed, waiting for the next frame boundary.
    typedef enum logic [0:0] {
        ST_FILL    = 1'b0,
        ST_PENDING = 1'b1
    } seq_state_t;

endpackage

// File: rtl/glyph_dbuf.sv
// Double-buffered glyph ID store for one text row.
// Purpose: holds a shadow message that game logic edits and an active
// message that the pixel path reads. Commit snapshots length and origin
// into shadow registers; swap copies the whole shadow set into the active set.
// Ports:
//   clk, reset          pixel clock, synchronous active-high reset
//   wr_en, wr_addr,     shadow cell write
//   wr_id
//   commit, commit_len, latch length (already saturated) and origin
//   commit_x, commit_y
//   swap                copy shadow ids/len/origin into the active set
//   active_ids          flattened active cells, cell k at [k*6 +: 6]
//   active_len, active_x, active_y   active length and row origin
module glyph_dbuf
    import text_pkg::*;
#(
    parameter int MAX_CHARS = 8,
    localparam int AW = $clog2(MAX_CHARS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [5:0]             wr_id,
    input  logic                   commit,
    input  logic [AW:0]            commit_len,
    input  logic [9:0]             commit_x,
    input  logic [8:0]             commit_y,
    input  logic                   swap,
    output logic [MAX_CHARS*6-1:0] active_ids,
    output logic [AW:0]            active_len,
    output logic [9:0]             active_x,
    output logic [8:0]             active_y
);

    logic [5:0] shadow_mem [MAX_CHARS];
    logic [5:0] active_mem [MAX_CHARS];
    logic [AW:0] shadow_len;
    logic [9:0]  shadow_x;
    logic [8:0]  shadow_y;

    // Shadow side: the write lands on the same edge as a commit, so a
    // write issued together with its commit is part of that message.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_CHARS; i++) shadow_mem[i] <= BLANK_ID;
            shadow_len <= '0;
            shadow_x   <= '0;
            shadow_y   <= '0;
        end else begin
            if (wr_en) shadow_mem[wr_addr] <= wr_id;
            if (commit) begin
                shadow_len <= commit_len;
                shadow_x   <= commit_x;
                shadow_y   <= commit_y;
            end
        end
    end

    // Active side: copied wholesale; the shadow keeps its content so the
    // next message can be a partial edit of this one.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_CHARS; i++) active_mem[i] <= BLANK_ID;
            active_len <= '0;
            active_x   <= '0;
            active_y   <= '0;
        end else if (swap) begin
            for (int i = 0; i < MAX_CHARS; i++) active_mem[i] <= shadow_mem[i];
            active_len <= shadow_len;
            active_x   <= shadow_x;
            active_y   <= shadow_y;
        end
    end

    always_comb begin
        active_ids = '0;
        for (int i = 0; i < MAX_CHARS; i++) active_ids[i*6 +: 6] = active_mem[i];
    end

endmodule

// File: rtl/text_row_sequencer.sv
// Text row sequencer for the VGA glyph renderer.
// Purpose: for each pixel (x,y) finds the character cell the pixel falls in
// and presents that cell's glyph ID and start coordinates one cycle later.
// The message is edited in a shadow buffer and becomes visible only at the
// next frame_start after a commit, so a frame never mixes two messages.
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   x, y                  current pixel
//   frame_start           one-cycle pulse at start of vertical blank
//   wr_valid/wr_ready     shadow write handshake (wr_addr, wr_id)
//   wr_commit             close the shadow message (wr_len, origin_x/y)
//   pending               commit taken, waiting for frame_start
//   glyph_*               renderer request, registered, 1-cycle latency
//
// Handshake: a write or commit is taken on a cycle where it is asserted and
// wr_ready=1. wr_ready is 1 only in FILL and does not depend on wr_valid or
// wr_commit; requests presented while wr_ready=0 are dropped, not held.
module text_row_sequencer
    import text_pkg::*;
#(
    parameter int MAX_CHARS  = 8,
    parameter int CHAR_PITCH = 48,
    parameter int GLYPH_W    = 40,
    parameter int GLYPH_H    = 40,
    localparam int AW = $clog2(MAX_CHARS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    x,
    input  logic [8:0]    y,
    input  logic          frame_start,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [5:0]    wr_id,
    input  logic          wr_commit,
    input  logic [AW:0]   wr_len,
    input  logic [9:0]    origin_x,
    input  logic [8:0]    origin_y,
    output logic          pending,
    output logic [5:0]    glyph_id,
    output logic [9:0]    glyph_xstart,
    output logic [8:0]    glyph_ystart,
    output logic [6:0]    glyph_wwidth,
    output logic [6:0]    glyph_wheight,
    output logic          glyph_active
);

    localparam logic [AW:0] MAX_LEN = (AW+1)'(MAX_CHARS);

    seq_state_t state, state_next;
    logic wr_en, commit_en, swap_en;
    logic [AW:0] commit_len;

    logic [MAX_CHARS*6-1:0] act_ids;
    logic [AW:0] act_len;
    logic [9:0]  act_x;
    logic [8:0]  act_y;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= ST_FILL;
        else       state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    // frame_start in FILL is ignored, including the cycle that commits.
    always_comb begin
        state_next = state;
        case (state)
            ST_FILL:    if (wr_commit)   state_next = ST_PENDING;
            ST_PENDING: if (frame_start) state_next = ST_FILL;
            default:    state_next = ST_FILL;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        wr_ready  = (state == ST_FILL);
        pending   = (state == ST_PENDING);
        wr_en     = wr_valid  && (state == ST_FILL);
        commit_en = wr_commit && (state == ST_FILL);
        swap_en   = frame_start && (state == ST_PENDING);
    end

    assign commit_len = (wr_len > MAX_LEN) ? MAX_LEN : wr_len;

    glyph_dbuf #(.MAX_CHARS(MAX_CHARS)) u_dbuf (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_id      (wr_id),
        .commit     (commit_en),
        .commit_len (commit_len),
        .commit_x   (origin_x),
        .commit_y   (origin_y),
        .swap       (swap_en),
        .active_ids (act_ids),
        .active_len (act_len),
        .active_x   (act_x),
        .active_y   (act_y)
    );

    // ---------------- cell selection ----------------
    // Cell xstarts grow with k, so scanning upward and keeping the last
    // match yields the largest k whose xstart is at or left of x.
    // Arithmetic is 11 bits so origin + k*pitch never wraps.
    logic        sel_found;
    logic [10:0] sel_x;
    logic [5:0]  sel_id;
    logic [10:0] cell_x;
    logic        hit;

    always_comb begin
        sel_found = 1'b0;
        sel_x     = '0;
        sel_id    = '0;
        cell_x    = '0;
        for (int k = 0; k < MAX_CHARS; k++) begin
            cell_x = {1'b0, act_x} + 11'(k * CHAR_PITCH);
            if ((k < int'(act_len)) && ({1'b0, x} >= cell_x)) begin
                sel_found = 1'b1;
                sel_x     = cell_x;
                sel_id    = act_ids[k*6 +: 6];
            end
        end
    end

    // A cell starting off-screen is never drawn, even if x reaches it.
    always_comb begin
        hit = sel_found
           && ({1'b0, x} < sel_x + 11'(GLYPH_W))
           && (sel_x <= 11'(SCREEN_W - 1))
           && ({1'b0, y} >= {1'b0, act_y})
           && ({1'b0, y} <  {1'b0, act_y} + 10'(GLYPH_H))
           && (sel_id != BLANK_ID);
    end

    always_ff @(posedge clk) begin
        if (reset || !hit) begin
            glyph_active <= 1'b0;
            glyph_id     <= '0;
            glyph_xstart <= '0;
            glyph_ystart <= '0;
        end else begin
            glyph_active <= 1'b1;
            glyph_id     <= sel_id;
            glyph_xstart <= sel_x[9:0];
            glyph_ystart <= act_y;
        end
    end

    assign glyph_wwidth  = 7'(GLYPH_W);
    assign glyph_wheight = 7'(GLYPH_H);

endmodule

// File: doc/text_row_sequencer.md
Name: text_row_sequencer

Overview:
- Drives a glyph renderer from a stored message: for each VGA pixel (x,y) it selects the character cell the pixel falls in and emits that cell's glyph ID, xstart and ystart.
- Game logic writes the message (e.g. "HOCKEY", scores) into a shadow buffer through a valid/ready port.
- The new message becomes visible only at the next frame boundary, so no tearing.
- Sits between game/score FSMs and the glyph renderer in the VGA pixel path.

Parameters:
- MAX_CHARS, 8, character cells per row (power of 2).
- CHAR_PITCH, 48, horizontal distance in pixels between cell xstarts.
- GLYPH_W, 40, glyph width passed to the renderer (fits 7 bits).
- GLYPH_H, 40, glyph height passed to the renderer (fits 7 bits).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- x  in  10  current pixel column
- y  in  9  current pixel row
- frame_start  in  1  one-cycle pulse at start of vertical blank
- wr_valid  in  1  write request to shadow buffer
- wr_ready  out  1  shadow buffer accepts writes
- wr_addr  in  log2(MAX_CHARS)  cell index
- wr_id  in  6  glyph ID for that cell
- wr_commit  in  1  marks shadow message complete (needs wr_ready=1)
- wr_len  in  log2(MAX_CHARS)+1  number of cells in committed message
- origin_x  in  10  row xstart, sampled on commit
- origin_y  in  9  row ystart, sampled on commit
- pending  out  1  commit accepted, swap not yet done
- glyph_id  out  6  ID for renderer
- glyph_xstart  out  10  cell xstart
- glyph_ystart  out  9  row ystart
- glyph_wwidth  out  7  constant GLYPH_W
- glyph_wheight  out  7  constant GLYPH_H
- glyph_active  out  1  pixel lies in a valid, non-blank cell

Behaviour:
- Reset:
  - Both buffers fill with BLANK_ID (63); active and shadow len = 0; origins = 0.
  - State FILL; pending=0; wr_ready=1.
  - glyph_id=0, glyph_xstart=0, glyph_ystart=0, glyph_active=0.
  - Reset mid-swap or mid-write discards everything.
- Write port:
  - A write occurs on a cycle with wr_valid & wr_ready; shadow[wr_addr] <= wr_id.
  - wr_addr >= MAX_CHARS cannot occur (width-limited).
- State FILL (wr_ready=1): wr_commit latches wr_len (saturates at MAX_CHARS), origin_x and origin_y into shadow registers and moves to PENDING.
  - Write and commit in the same cycle: the write is included in the commit.
- State PENDING (wr_ready=0, pending=1):
  - Writes and commits are ignored.
  - On frame_start: active buffer, len and origins <= shadow copy (or pointer swap); return to FILL.
  - Commit and frame_start in the same cycle while in FILL: commit taken; swap waits for the next frame_start.
  - frame_start while in FILL: no effect.
- Shadow content persists after a swap; partial edits followed by commit are allowed.
- Cell selection (combinational, then registered; latency exactly 1 cycle from x/y to all glyph_* outputs):
  - Selected cell k = largest k < len with x >= origin_x + k*CHAR_PITCH. Compute in 11 bits, no wrap.
  - glyph_active=1 iff such k exists, x < origin_x + k*CHAR_PITCH + GLYPH_W, origin_y <= y < origin_y + GLYPH_H, and active[k] != BLANK_ID.
  - When active: glyph_id=active[k], glyph_xstart=origin_x + k*CHAR_PITCH, glyph_ystart=origin_y.
  - When inactive: glyph_id=0, glyph_xstart=0, glyph_ystart=0.
  - Cell whose xstart > 639: treated as inactive.
- len=0: glyph_active never asserts.

Decomposition:
- Shared package text_pkg:
  - Glyph ID constants: DASH=0, A=1, B=2, C=3, D=4, E=5, G=7, H=8, K=11, M=13, O=15, R=18, U=21, V=22, Y=25, one..four=29..32, five=24, six..eight=26..28.
  - BLANK_ID=63, SCREEN_W=640, SCREEN_H=480.
- Sub-module glyph_dbuf: double-buffered MAX_CHARS x 6 register file with swap control, plus len and origin shadow registers.

Test Plan:
- Reset, then sweep x=0..639 at y=60 -> glyph_active=0 everywhere, all outputs 0.
- Write H,O,C,K,E,Y (8,15,3,11,5,25) to cells 0..5; commit len=6, origin (100,50); pulse frame_start -> next cycle pending=0. Drive x=150,y=60 -> one cycle later glyph_id=15, glyph_xstart=148, glyph_ystart=50, glyph_active=1.
- Same setup, x=388,y=60 (cell 6 >= len) -> glyph_active=0. x=190,y=60 (gap, 148+40=188) -> glyph_active=0. x=150,y=90 (below row) -> glyph_active=0.
- After commit, before frame_start: wr_valid with addr 0, id 29 -> wr_ready=0, pending=1, write ignored. x=110,y=60 still shows glyph_id=8 until frame_start.
- Assert commit and frame_start in the same cycle -> no swap that cycle; swap on the following frame_start. Write and commit in the same cycle -> the write appears after the swap.
- Write BLANK_ID to cell 2, then commit and swap -> x=200,y=60 gives glyph_active=0. Assert reset mid-PENDING -> pending=0, wr_ready=1, all cells blank.
